// File: rtl/img_pkg.sv
// Shared image-path definitions: default frame geometry, pixel size and the
// byte-writer/reader state encoding.
package img_pkg;

    localparam int IMG_HEIGHT      = 512;
    localparam int IMG_WIDTH       = 768;
    localparam int BYTES_PER_PIXEL = 3;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        EMIT_R,
        EMIT_G,
        EMIT_B,
        DONE
    } img_state_t;

endpackage

// File: rtl/img_addr_gen.sv
// Raster-to-file address generator. The file stores the bottom row first, so
// the row base starts at the last row and steps down by one row stride per
// row; within a row the column offset steps by one pixel (3 bytes). Only
// constant adds/subtracts are used, no multiplier.
module img_addr_gen
    import img_pkg::*;
#(
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int WIDTH  = IMG_WIDTH,
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              last_col,
    output logic              last_row
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] ROW_BASE_INIT = ADDR_W'(BYTES_PER_PIXEL * WIDTH * (HEIGHT - 1));
    localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(BYTES_PER_PIXEL * WIDTH);
    localparam logic [ADDR_W-1:0] PIX_STRIDE    = ADDR_W'(BYTES_PER_PIXEL);
    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_off;

    // Counters: load at frame start, step after each completed pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            col_off  <= '0;
        end else if (clear) begin
            col      <= '0;
            row      <= '0;
            row_base <= ROW_BASE_INIT;
            col_off  <= '0;
        end else if (advance) begin
            if (last_col) begin
                col     <= '0;
                col_off <= '0;
                // Final pixel of the frame leaves row/base alone; the next
                // start reloads everything anyway.
                if (!last_row) begin
                    row      <= row + 1'b1;
                    row_base <= row_base - ROW_STRIDE;
                end
            end else begin
                col     <= col + 1'b1;
                col_off <= col_off + PIX_STRIDE;
            end
        end
    end

    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    assign pix_addr = row_base + col_off;

endmodule

// File: rtl/image_byte_writer.sv
// Pixel-stream to file-layout byte writer: accepts one RGB pixel, then emits
// its R, G and B bytes as three memory writes, stalling on mem_ready.
module image_byte_writer
    import img_pkg::*;
#(
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int WIDTH  = IMG_WIDTH,
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done
);

    img_state_t        state, state_nx;
    logic [7:0]        r_q, g_q, b_q;
    logic              clear, advance;
    logic [ADDR_W-1:0] pix_addr;
    logic              last_col, last_row;

    img_addr_gen #(
        .HEIGHT (HEIGHT),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .advance  (advance),
        .pix_addr (pix_addr),
        .last_col (last_col),
        .last_row (last_row)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Capture the pixel on the accept handshake; held through the three writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (state == ACCEPT && pix_valid) begin
            r_q <= pix_r;
            g_q <= pix_g;
            b_q <= pix_b;
        end
    end

    // Next state, counter control and state-decoded outputs. Outputs depend
    // only on the registered state, so they are zero right after reset.
    always_comb begin
        state_nx   = state;
        clear      = 1'b0;
        advance    = 1'b0;
        pix_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACCEPT;
                    clear    = 1'b1;
                end
            end
            ACCEPT: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (pix_valid) state_nx = EMIT_R;
            end
            EMIT_R: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = pix_addr;
                mem_data = r_q;
                if (mem_ready) state_nx = EMIT_G;
            end
            EMIT_G: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = pix_addr + ADDR_W'(1);
                mem_data = g_q;
                if (mem_ready) state_nx = EMIT_B;
            end
            EMIT_B: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = pix_addr + ADDR_W'(2);
                mem_data = b_q;
                if (mem_ready) begin
                    advance  = 1'b1;
                    state_nx = (last_col && last_row) ? DONE : ACCEPT;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_image_byte_writer.sv
// Bench for image_byte_writer on a 4x2 frame, random pixel data checked
// against a raster-to-file address/data model.
module tb_image_byte_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 5;
    localparam int P  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    pix_r = '0, pix_g = '0, pix_b = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_ready = 1'b1;
    logic          busy;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    image_byte_writer #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log of completed handshakes, sampled mid-cycle.
    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], acc_cyc_q[$];
    int done_cnt = 0, done_cyc = 0;
    bit done_busy_bad = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && mem_ready) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(int'(mem_data));
                wr_cyc_q.push_back(cyc);
            end
            if (pix_valid && pix_ready) acc_cyc_q.push_back(cyc);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_busy_bad = 1;
            end
        end
    end

    // Reference model: raster pixel p goes to file row (H-1-p/W), column p%W.
    logic [23:0] px [P];

    function automatic int exp_addr(input int p, input int k);
        return ((H - 1 - p / W) * W + p % W) * 3 + k;
    endfunction

    function automatic int exp_byte(input int p, input int k);
        return int'((px[p] >> (8 * (2 - k))) & 24'hFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pixels();
        for (int i = 0; i < P; i++) px[i] = 24'($urandom);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
        done_cnt = 0;
        done_busy_bad = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pixel(input int idx);
        int n = 0;
        pix_valid = 1'b1;
        {pix_r, pix_g, pix_b} = px[idx];
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!pix_ready) begin
            errors++;
            $display("FAIL send_pixel_timeout px=%0d pix_ready=%b required 1", idx, pix_ready);
        end else begin
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL frame_done_timeout frame_done=%b required 1", frame_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_mem_data got %0d want 0", mem_data); end
    endtask

    task automatic test_frame();
        new_pixels();
        px[0] = {8'd10, 8'd20, 8'd30};
        px[3] = 24'hAABBCC;
        clear_log();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_rise got %b want 1", busy); end
        for (int p = 0; p < P; p++) send_pixel(p);
        wait_done();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after got %b want 0", busy); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", done_cnt); end
        checks++; if (done_busy_bad) begin errors++; $display("FAIL frame_done_busy got busy=1 want 0"); end
        checks++;
        if (wr_addr_q.size() != 3 * P || acc_cyc_q.size() != P) begin
            errors++;
            $display("FAIL frame_counts got wr=%0d acc=%0d want %0d/%0d", wr_addr_q.size(), acc_cyc_q.size(), 3 * P, P);
        end else begin
            for (int i = 0; i < 3 * P; i++) begin
                checks++;
                if (wr_addr_q[i] != exp_addr(i / 3, i % 3) || wr_data_q[i] != exp_byte(i / 3, i % 3)) begin
                    errors++;
                    $display("FAIL frame_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wr_addr_q[i], wr_data_q[i],
                             exp_addr(i / 3, i % 3), exp_byte(i / 3, i % 3));
                end
                checks++;
                if (wr_cyc_q[i] != acc_cyc_q[i / 3] + 1 + i % 3) begin
                    errors++;
                    $display("FAIL frame_latency[%0d] got cyc=%0d want %0d", i, wr_cyc_q[i], acc_cyc_q[i / 3] + 1 + i % 3);
                end
            end
            checks++;
            if (done_cyc != wr_cyc_q[3 * P - 1] + 1) begin
                errors++;
                $display("FAIL frame_done_cycle got %0d want %0d", done_cyc, wr_cyc_q[3 * P - 1] + 1);
            end
        end
    endtask

    task automatic test_stall();
        new_pixels();
        clear_log();
        pulse_start();
        send_pixel(0);
        send_pixel(1);
        send_pixel(2);
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_we !== 1'b1 || int'(mem_addr) != exp_addr(2, 1) || int'(mem_data) != exp_byte(2, 1)) begin
                errors++;
                $display("FAIL stall_hold[%0d] got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d", k, mem_we, mem_addr, mem_data,
                         exp_addr(2, 1), exp_byte(2, 1));
            end
            tick();
        end
        mem_ready = 1'b1;
        for (int p = 3; p < P; p++) send_pixel(p);
        wait_done();
        tick();
        checks++;
        if (wr_addr_q.size() != 3 * P) begin
            errors++;
            $display("FAIL stall_count got %0d want %0d", wr_addr_q.size(), 3 * P);
        end else begin
            for (int i = 0; i < 3 * P; i++) begin
                checks++;
                if (wr_addr_q[i] != exp_addr(i / 3, i % 3) || wr_data_q[i] != exp_byte(i / 3, i % 3)) begin
                    errors++;
                    $display("FAIL stall_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wr_addr_q[i], wr_data_q[i],
                             exp_addr(i / 3, i % 3), exp_byte(i / 3, i % 3));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int guard = 0;
        int seen [3 * P];
        new_pixels();
        clear_log();
        pulse_start();
        pix_valid = 1'b1;
        while (idx < P && guard < 200) begin
            {pix_r, pix_g, pix_b} = px[idx];
            if (pix_ready) idx++;
            tick();
            guard++;
        end
        pix_valid = 1'b0;
        wait_done();
        tick();
        checks++;
        if (acc_cyc_q.size() != P || wr_addr_q.size() != 3 * P) begin
            errors++;
            $display("FAIL b2b_counts got acc=%0d wr=%0d want %0d/%0d", acc_cyc_q.size(), wr_addr_q.size(), P, 3 * P);
        end else begin
            for (int i = 1; i < P; i++) begin
                checks++;
                if (acc_cyc_q[i] - acc_cyc_q[i - 1] != 4) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d] got %0d want 4", i, acc_cyc_q[i] - acc_cyc_q[i - 1]);
                end
            end
            foreach (seen[a]) seen[a] = 0;
            for (int i = 0; i < 3 * P; i++) begin
                if (wr_addr_q[i] >= 0 && wr_addr_q[i] < 3 * P) seen[wr_addr_q[i]]++;
                checks++;
                if (wr_data_q[i] != exp_byte(i / 3, i % 3)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got %0d want %0d", i, wr_data_q[i], exp_byte(i / 3, i % 3));
                end
            end
            for (int a = 0; a < 3 * P; a++) begin
                checks++;
                if (seen[a] != 1) begin
                    errors++;
                    $display("FAIL b2b_addr_cover addr=%0d got %0d writes want 1", a, seen[a]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        new_pixels();
        clear_log();
        pulse_start();
        for (int p = 0; p < 4; p++) send_pixel(p);
        tick();
        tick();
        checks++;
        if (mem_we !== 1'b1 || int'(mem_addr) != exp_addr(3, 2)) begin
            errors++;
            $display("FAIL rstmid_in_b got we=%b a=%0d want we=1 a=%0d", mem_we, mem_addr, exp_addr(3, 2));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (pix_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            mem_addr !== '0 || mem_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got rdy=%b we=%b busy=%b done=%b a=%0d d=%0d want all 0",
                     pix_ready, mem_we, busy, frame_done, mem_addr, mem_data);
        end
        checks++;
        if (wr_addr_q.size() != 11) begin
            errors++;
            $display("FAIL rstmid_writes got %0d want 11", wr_addr_q.size());
        end
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy=%b want 0", busy); end
        clear_log();
        pulse_start();
        send_pixel(0);
        checks++;
        if (mem_we !== 1'b1 || int'(mem_addr) != 12 || int'(mem_data) != exp_byte(0, 0)) begin
            errors++;
            $display("FAIL rstmid_restart got we=%b a=%0d d=%0d want we=1 a=12 d=%0d", mem_we, mem_addr, mem_data, exp_byte(0, 0));
        end
        for (int p = 1; p < P; p++) send_pixel(p);
        wait_done();
        tick();
    endtask

    task automatic test_start_ignored();
        new_pixels();
        clear_log();
        pulse_start();
        for (int p = 0; p < 5; p++) send_pixel(p);
        send_pixel(5);
        pulse_start();
        send_pixel(6);
        send_pixel(7);
        wait_done();
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL startign_idle[%0d] got busy=%b rdy=%b want 0/0", k, busy, pix_ready);
            end
            tick();
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL startign_done_count got %0d want 1", done_cnt); end
        checks++;
        if (wr_addr_q.size() != 3 * P) begin
            errors++;
            $display("FAIL startign_count got %0d want %0d", wr_addr_q.size(), 3 * P);
        end else begin
            for (int i = 0; i < 3 * P; i++) begin
                checks++;
                if (wr_addr_q[i] != exp_addr(i / 3, i % 3) || wr_data_q[i] != exp_byte(i / 3, i % 3)) begin
                    errors++;
                    $display("FAIL startign_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wr_addr_q[i], wr_data_q[i],
                             exp_addr(i / 3, i % 3), exp_byte(i / 3, i % 3));
                end
            end
        end
        new_pixels();
        clear_log();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startign_restart_busy got %b want 1", busy); end
        for (int p = 0; p < P; p++) send_pixel(p);
        wait_done();
        tick();
        checks++;
        if (wr_addr_q.size() != 3 * P || done_cnt != 1) begin
            errors++;
            $display("FAIL startign_second_frame got wr=%0d done=%0d want %0d/1", wr_addr_q.size(), done_cnt, 3 * P);
        end else begin
            checks++;
            if (wr_addr_q[0] != 12 || wr_addr_q[3 * P - 1] != 11 || wr_data_q[3 * P - 1] != exp_byte(P - 1, 2)) begin
                errors++;
                $display("FAIL startign_second_ends got first=%0d last=%0d d=%0d want 12/11/%0d",
                         wr_addr_q[0], wr_addr_q[3 * P - 1], wr_data_q[3 * P - 1], exp_byte(P - 1, 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
